// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - branch resolve shared constants, BHT counter encoding and helpers
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_e;

    // 010/011 are the only undefined B-type encodings
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// rtl/br_resolve_if.sv - EX-stage branch bundle between pipeline/comparator and br_resolve
// Ports: ex_* instruction fields and prediction, comparator handshake
// (br_unsigned/br_less/br_equal), redirect_valid/redirect_pc/flush back to fetch.
interface br_resolve_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            br_unsigned;
    logic            br_less;
    logic            br_equal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, br_less, br_equal,
        input  br_unsigned, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, br_less, br_equal,
        output br_unsigned, redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/br_bht.sv
// rtl/br_bht.sv - 2-bit bimodal branch history table
// Ports: clk, rst (sync, active-high), rd_idx/rd_pred combinational lookup,
// wr_en/wr_idx/wr_taken saturating counter update.
module br_bht
    import br_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int DEPTH = 1 << IDX_W;

    bht_cnt_e tbl [DEPTH];
    bht_cnt_e rd_cnt;

    // Plain array read: a same-cycle update is only visible after the edge,
    // so a colliding lookup sees the old counter.
    assign rd_cnt  = tbl[rd_idx];
    assign rd_pred = rd_cnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= WNT;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - EX-stage branch resolution, mispredict redirect, BHT and perf counters
// Ports: clk, rst (sync, active-high), stall, if_pc/if_pred_taken (BHT lookup),
// ex (br_resolve_if.slave: EX fields, comparator, redirect/flush),
// illegal_br, br_count, mispred_count.
module br_resolve
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    br_resolve_if.slave      ex,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            res;
    logic            legal;
    logic            cond;
    logic            br_taken;
    logic            mispredict;
    logic            bht_wr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;

    assign ex.br_unsigned    = ex.ex_funct3[1];
    assign ex.redirect_valid = redirect_q;
    assign ex.redirect_pc    = redirect_pc_q;
    assign ex.flush          = redirect_q;

    // The instruction in EX during a redirect cycle is wrong-path.
    assign res = ex.ex_valid & ~stall & ~redirect_q;

    assign legal = f3_legal(ex.ex_funct3);

    always_comb begin
        cond = 1'b0;
        case (ex.ex_funct3)
            F3_BEQ:          cond = ex.br_equal;
            F3_BNE:          cond = ~ex.br_equal;
            F3_BLT, F3_BLTU: cond = ex.br_less;
            F3_BGE, F3_BGEU: cond = ~ex.br_less;
            default:         cond = 1'b0;
        endcase
    end

    assign br_taken   = legal & cond;
    assign mispredict = res & ((ex.ex_is_branch & (br_taken != ex.ex_pred_taken))
                               | ex.ex_is_jump);
    assign bht_wr     = res & ex.ex_is_branch & legal;
    assign pc_plus4   = ex.ex_pc + XLEN'(4);
    assign next_pc    = (ex.ex_is_jump | br_taken) ? ex.ex_target : pc_plus4;

    br_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[BHT_IDX_W+1:2]),
        .rd_pred  (if_pred_taken),
        .wr_en    (bht_wr),
        .wr_idx   (ex.ex_pc[BHT_IDX_W+1:2]),
        .wr_taken (br_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_br    <= 1'b0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            // res already folds in stall, so these pulses self-clear while stalled
            redirect_q <= mispredict;
            illegal_br <= res & ex.ex_is_branch & ~legal;
            if (mispredict) begin
                redirect_pc_q <= next_pc;
            end
            if (bht_wr && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict && (mispred_count != '1)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0],
                              ex.ex_pc[XLEN-1:BHT_IDX_W+2], ex.ex_pc[1:0]};

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - directed self-checking bench for br_resolve
module tb_br_resolve;
    localparam int XLEN = 32;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             stall;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             illegal_br;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    int errors = 0;
    int checks = 0;

    br_resolve_if #(.XLEN(XLEN)) ex_if ();

    br_resolve #(
        .XLEN      (XLEN),
        .BHT_IDX_W (6),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex            (ex_if.slave),
        .illegal_br    (illegal_br),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic br, input logic jmp,
                         input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred,
                         input logic less, input logic eq);
        ex_if.ex_valid      = valid;
        ex_if.ex_is_branch  = br;
        ex_if.ex_is_jump    = jmp;
        ex_if.ex_funct3     = f3;
        ex_if.ex_pc         = pc;
        ex_if.ex_target     = tgt;
        ex_if.ex_pred_taken = pred;
        ex_if.br_less       = less;
        ex_if.br_equal      = eq;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic [31:0] rpc,
                           input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, ".redirect_valid"}, 64'(ex_if.redirect_valid), 64'(rv));
        chk({tag, ".flush"},          64'(ex_if.flush),          64'(rv));
        chk({tag, ".redirect_pc"},    64'(ex_if.redirect_pc),    64'(rpc));
        chk({tag, ".br_count"},       64'(br_count),             64'(bc));
        chk({tag, ".mispred_count"},  64'(mispred_count),        64'(mc));
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        if_pc = 32'h40;
        idle();
        step();
        step();
        chk_out("reset", 0, 32'h0, 0, 0);
        chk("reset.illegal_br", 64'(illegal_br), 64'd0);
        chk("reset.pred_0x40", 64'(if_pred_taken), 64'd0);
        rst = 1'b0;

        // 1: BEQ taken, predicted not-taken
        drive(1, 1, 0, 3'b000, 32'h40, 32'h80, 0, 0, 1);
        step();
        chk_out("t1", 1, 32'h80, 1, 1);
        chk("t1.pred_0x40", 64'(if_pred_taken), 64'd1);
        idle();
        step();
        chk_out("t1.after", 0, 32'h80, 1, 1);

        // 2: BLTU not taken, predicted not-taken
        drive(1, 1, 0, 3'b110, 32'h200, 32'h400, 0, 0, 0);
        #1;
        chk("t2.br_unsigned", 64'(ex_if.br_unsigned), 64'd1);
        step();
        chk_out("t2", 0, 32'h80, 2, 1);
        idle();

        // 3: BNE not taken, predicted taken; next EX cycle is wrong-path
        drive(1, 1, 0, 3'b001, 32'h100, 32'h300, 1, 0, 1);
        #1;
        chk("t3.br_unsigned", 64'(ex_if.br_unsigned), 64'd0);
        step();
        chk_out("t3", 1, 32'h104, 3, 2);
        step();
        chk_out("t3.ignored", 0, 32'h104, 3, 2);
        idle();

        // 4: saturate one entry at 11, then one not-taken
        if_pc = 32'h80;
        drive(1, 1, 0, 3'b000, 32'h80, 32'hC0, 1, 0, 1);
        #1;
        chk("t4.pred_before", 64'(if_pred_taken), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4.train_rv", 64'(ex_if.redirect_valid), 64'd0);
            chk("t4.train_pred", 64'(if_pred_taken), 64'd1);
        end
        chk_out("t4.trained", 0, 32'h104, 7, 2);
        drive(1, 1, 0, 3'b000, 32'h80, 32'hC0, 1, 0, 0);
        step();
        chk_out("t4.nt", 1, 32'h84, 8, 3);
        chk("t4.pred_after_nt", 64'(if_pred_taken), 64'd1);
        idle();
        step();

        // 5: illegal funct3
        drive(1, 1, 0, 3'b010, 32'h80, 32'hC0, 0, 1, 1);
        step();
        chk("t5.illegal", 64'(illegal_br), 64'd1);
        chk_out("t5", 0, 32'h84, 8, 3);
        chk("t5.pred", 64'(if_pred_taken), 64'd1);
        idle();
        step();
        chk("t5.illegal_drop", 64'(illegal_br), 64'd0);

        // fall-through address wraps past the top of the address space
        drive(1, 1, 0, 3'b000, 32'hFFFF_FFFC, 32'h500, 1, 0, 0);
        step();
        chk_out("wrap", 1, 32'h0, 9, 4);
        idle();
        step();

        // 6: JAL under stall, then released, then reset in redirect cycle
        stall = 1'b1;
        drive(1, 0, 1, 3'b000, 32'hFFFF_FFFC, 32'h1000, 0, 0, 0);
        step();
        chk_out("t6.stall", 0, 32'h0, 9, 4);
        stall = 1'b0;
        step();
        chk_out("t6.jump", 1, 32'h1000, 9, 5);
        rst = 1'b1;
        step();
        chk_out("t6.rst", 0, 32'h0, 0, 0);
        chk("t6.rst.illegal", 64'(illegal_br), 64'd0);
        chk("t6.rst.pred_0x80", 64'(if_pred_taken), 64'd0);
        rst = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
